anemometer_freq_gen: RTL

// - Anemometer emulator: turns an 8-bit wind-speed code into a square wave of code*HZ_PER_LSB Hz.
// - Drives the anemometer frequency input of the SoC for bench and board self-test, closing the loop with the measurement block.
// - Codes arrive over a valid/ready handshake; the half-period comes from an iterative divider; rate changes are glitch-free.

---
 rtl/anemo_gen_pkg.sv | 19 +
 rtl/anemo_gen_div.sv | 76 +++++++
 rtl/anemometer_freq_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/anemo_gen_pkg.sv
// rtl/anemo_gen_pkg.sv - shared types and sizing helpers for the anemometer frequency generator
package anemo_gen_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} anemo_gen_state_t;

  localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
  localparam int DEFAULT_HZ_PER_LSB  = 1;
  localparam int DIVIDEND            = DEFAULT_CLK_FREQ_HZ / (2 * DEFAULT_HZ_PER_LSB);

  // Width that holds the largest half-period (code 1).
  function automatic int half_w(input int clk_hz);
    return $clog2(clk_hz / 2 + 1);
  endfunction

  function automatic int dividend_of(input int clk_hz, input int hz_per_lsb);
    return clk_hz / (2 * hz_per_lsb);
  endfunction

endpackage

// File: rtl/anemo_gen_div.sv
// rtl/anemo_gen_div.sv - restoring divider, constant dividend / code, one quotient bit per cycle
module anemo_gen_div
  import anemo_gen_pkg::*;
#(
  parameter int DIVIDEND = 25_000_000,
  parameter int HALF_W   = 25,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [HALF_W-1:0] quotient
);

  localparam int CNT_W = $clog2(HALF_W + 1);
  localparam logic [HALF_W-1:0] DIVIDEND_V = HALF_W'(DIVIDEND);

  logic              active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_sub;

  // Dividend bits are shifted out of the quotient register as quotient bits shift in.
  always_comb begin
    rem_shift = {rem[DATA_W-1:0], quotient[HALF_W-1]};
    rem_sub   = rem_shift - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        dvs <= divisor;
        if (divisor == '0) begin
          quotient <= '0;
          done     <= 1'b1;
          active   <= 1'b0;
        end else begin
          quotient <= DIVIDEND_V;
          bit_cnt  <= CNT_W'(HALF_W);
          active   <= 1'b1;
        end
      end else if (active) begin
        if (rem_shift >= {1'b0, dvs}) begin
          rem      <= rem_sub;
          quotient <= {quotient[HALF_W-2:0], 1'b1};
        end else begin
          rem      <= rem_shift;
          quotient <= {quotient[HALF_W-2:0], 1'b0};
        end
        bit_cnt <= bit_cnt - CNT_W'(1);
        if (bit_cnt == CNT_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  // Busy covers the done cycle so the caller never sees a gap before the result lands.
  assign busy = active || done;

endmodule

// File: rtl/anemometer_freq_gen.sv
// rtl/anemometer_freq_gen.sv - code-to-square-wave anemometer emulator with glitch-free rate changes
// Optional pulse_count output enabled by ANEMO_GEN_PULSE_CNT_EN.
module anemometer_freq_gen
  import anemo_gen_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int HZ_PER_LSB  = 1,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              freq_out,
  output logic              rise_tick,
  output logic              running
`ifdef ANEMO_GEN_PULSE_CNT_EN
  ,
  output logic [15:0]       pulse_count
`endif
);

  localparam int HALF_W  = half_w(CLK_FREQ_HZ);
  localparam int DIV_VAL = dividend_of(CLK_FREQ_HZ, HZ_PER_LSB);

  logic              div_busy;
  logic              div_done;
  logic [HALF_W-1:0] div_quotient;
  logic              pending;
  logic [HALF_W-1:0] pending_half;
  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] counter;
  anemo_gen_state_t  state;

  logic              accept;
  logic              have_new;
  logic              boundary;
  logic              consume;
  logic [HALF_W-1:0] new_half;

  assign code_ready = !div_busy && !pending;
  assign accept     = code_valid && code_ready;
  // A quotient finishing this cycle is usable straight away, without a pass through pending.
  assign have_new   = pending || div_done;
  assign new_half   = div_done ? div_quotient : pending_half;
  assign boundary   = (state == ST_RUN) && (counter == half - HALF_W'(1));
  assign consume    = have_new && ((state == ST_IDLE) || boundary);

  anemo_gen_div #(
    .DIVIDEND (DIV_VAL),
    .HALF_W   (HALF_W),
    .DATA_W   (DATA_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .divisor  (code_in),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= 1'b0;
      pending_half <= '0;
    end else if (consume) begin
      pending <= 1'b0;
    end else if (div_done) begin
      pending      <= 1'b1;
      pending_half <= div_quotient;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      half      <= '0;
      counter   <= '0;
      freq_out  <= 1'b0;
      rise_tick <= 1'b0;
      running   <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          freq_out <= 1'b0;
          running  <= 1'b0;
          counter  <= '0;
          if (have_new && new_half != '0) begin
            half      <= new_half;
            freq_out  <= 1'b1;
            rise_tick <= 1'b1;
            running   <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // New rates only land here, so every half-period runs to full length.
          if (boundary) begin
            counter <= '0;
            if (have_new && new_half == '0) begin
              freq_out <= 1'b0;
              running  <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              if (have_new) half <= new_half;
              freq_out  <= !freq_out;
              rise_tick <= !freq_out;
            end
          end else begin
            counter <= counter + HALF_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ANEMO_GEN_PULSE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_count <= '0;
    end else if (accept) begin
      pulse_count <= '0;
    end else if (rise_tick) begin
      pulse_count <= pulse_count + 16'd1;
    end
  end
`endif

endmodule
